cpu_mem_bridge: RTL and testbench
=================================

# cpu_mem_bridge

Single-port memory bridge between the five-stage CPU core's instruction and data SRAM-style ports and the SoC unified memory bus. Arbitrates the two CPU request channels onto one request/grant/response bus, keeps one transaction outstanding, and returns read data with a one-cycle done pulse per port. It also discards in-flight instruction fetches on pipeline cancel and flags protocol violations.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits; range 1–15.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- inst_en  in  1  instruction read request; held until inst_done or cancel
- inst_addr  in  32  fetch address, word aligned, stable while inst_en
- inst_rdata  out  32  fetched word, valid with inst_done, held after
- inst_done  out  1  one-cycle completion pulse
- data_en  in  1  data request; held until data_done
- data_wen  in  4  byte enables; 0 = read, nonzero = write
- data_addr  in  32  data address, stable while data_en
- data_wdata  in  32  store data
- data_rdata  out  32  load word, valid with data_done, held after
- data_done  out  1  one-cycle completion pulse
- cancel  in  1  pipeline flush; kills pending or in-flight fetch
- mem_req  out  1  bus request
- mem_wr  out  1  1 = write
- mem_be  out  4  byte enables (4'hF for reads)
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_gnt  in  1  request accepted when mem_req & mem_gnt at clock edge
- mem_rvalid  in  1  read response valid, at least one cycle after grant
- mem_rdata  in  32  read response data
- bus_err  out  1  sticky: mem_rvalid seen outside RESP

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Registered source port: SEL_I or SEL_D.
- IDLE: sample data_en and inst_en. If neither is asserted, stay in IDLE. Otherwise arbitrate, latch addr/be/wdata/wr into output registers, and go to REQ.
- Arbitration: data wins over inst, except when streak == STARVE_LIMIT and inst_en is asserted; then inst wins. inst_en & cancel in IDLE is not arbitrated.
- streak (4-bit counter):
  - +1 on each data grant while inst_en is high, saturating at STARVE_LIMIT.
  - Cleared on an inst grant, or when inst_en is low at a data grant.
- REQ: mem_req = 1 and bus fields driven from registers. On mem_gnt, a write goes to DONE and a read goes to RESP. Without mem_gnt, stay in REQ with all fields unchanged.
- RESP: wait for mem_rvalid, latch mem_rdata into the selected port's rdata register, then go to DONE.
- DONE: pulse the selected port's done, then return to IDLE.
- Cancel with SEL_I:
  - In REQ: the request continues; the bus transaction is never dropped.
  - In REQ or RESP: set the kill flag.
  - Killed fetch: on return, inst_rdata is not updated and no inst_done pulse fires; the FSM still passes through DONE.
  - The kill flag clears on entry to IDLE.
  - Cancel has no effect on data transactions.
- bus_err: set when mem_rvalid = 1 in any state other than RESP. Cleared only by reset. The stray response data is ignored.

## Timing
- Reset values:
  - State IDLE, streak 0, kill flag 0.
  - mem_req 0, mem_wr 0, mem_be 0, mem_addr 0, mem_wdata 0.
  - inst_rdata 0, data_rdata 0, inst_done 0, data_done 0, bus_err 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Read, zero wait:
  - Cycle 0: en high in IDLE.
  - Cycle 1: mem_req high, gnt sampled.
  - Cycle 2: rvalid.
  - Cycle 3: done pulse, with rdata valid.
  - Minimum read latency is 3 cycles; each extra gnt or rvalid wait adds 1 cycle.
- Write, zero wait: en at cycle 0, mem_req at cycle 1, done at cycle 2.
- The requester drops en on the edge ending the done cycle. The FSM is in IDLE the next cycle and re-arbitrates. Back-to-back issue rate is one transaction per 3 cycles for writes and 4 cycles for reads.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops mem_req. Any later bus response raises bus_err.

## Test plan
- Single read: inst_en with addr 0xBFC00000; gnt on first REQ cycle; rvalid with 0x3C080001 one cycle later -> inst_done at cycle 3, inst_rdata = 0x3C080001, mem_be = 4'hF, mem_wr = 0.
- Write with wait states: data_wen = 4'b0011, addr 0x1000, wdata 0xAABBCCDD; gnt held low 2 cycles -> mem_req held 3 cycles with fields stable; data_done 1 cycle after the gnt cycle; no rvalid required.
- Simultaneous requests: inst_en and data_en both high in IDLE -> data served first, inst served next; streak = 1.
- Starvation with STARVE_LIMIT = 2: inst_en held; data reissued after each done -> grant order D, D, I, D; streak returns to 0 after the I grant.
- Cancel: cancel pulses during RESP of a fetch; rvalid with 0xDEADBEEF -> no inst_done, inst_rdata keeps its old value, FSM reaches IDLE.
- Stray response: mem_rvalid pulsed in IDLE -> bus_err = 1 and stays 1; the next read completes normally; reset clears bus_err.

Source files
------------

// File: rtl/cpu_mem_bridge_if.sv
// Unified memory bus between the CPU bridge (master) and the SoC memory system (slave).
// One request/grant phase per transaction; read data returns on mem_rvalid.
interface cpu_mem_bridge_if;
   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Arbitrates the CPU instruction and data ports onto a single-outstanding memory bus,
// with starvation protection for fetches, fetch kill on pipeline cancel and stray-response detection.
module cpu_mem_bridge #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_en,
   input  logic [31:0]         inst_addr,
   output logic [31:0]         inst_rdata,
   output logic                inst_done,
   input  logic                data_en,
   input  logic [3:0]          data_wen,
   input  logic [31:0]         data_addr,
   input  logic [31:0]         data_wdata,
   output logic [31:0]         data_rdata,
   output logic                data_done,
   input  logic                cancel,
   cpu_mem_bridge_if.master    bus,
   output logic                bus_err
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   typedef enum logic {SEL_I, SEL_D} sel_t;

   state_t      state_q, state_d;
   sel_t        sel_q, sel_d;
   logic [3:0]  streak_q, streak_d;
   logic        kill_q, kill_d;
   logic        req_q, req_d;
   logic        wr_q, wr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic        inst_done_q, inst_done_d;
   logic        data_done_q, data_done_d;
   logic        bus_err_q, bus_err_d;

   logic        inst_ok;
   logic        cancel_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= SEL_I;
         streak_q     <= '0;
         kill_q       <= 1'b0;
         req_q        <= 1'b0;
         wr_q         <= 1'b0;
         be_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         inst_done_q  <= 1'b0;
         data_done_q  <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         streak_q     <= streak_d;
         kill_q       <= kill_d;
         req_q        <= req_d;
         wr_q         <= wr_d;
         be_q         <= be_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_done_q  <= inst_done_d;
         data_done_q  <= data_done_d;
         bus_err_q    <= bus_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      streak_d     = streak_q;
      kill_d       = kill_q;
      req_d        = req_q;
      wr_d         = wr_q;
      be_d         = be_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_done_d  = 1'b0;
      data_done_d  = 1'b0;
      bus_err_d    = bus_err_q | (bus.mem_rvalid && (state_q != RESP));

      // A fetch being cancelled in the same cycle is not eligible for arbitration.
      inst_ok    = inst_en & ~cancel;
      cancel_hit = cancel && (sel_q == SEL_I) && ((state_q == REQ) || (state_q == RESP));

      unique case (state_q)
         IDLE: begin
            if (data_en || inst_ok) begin
               state_d = REQ;
               req_d   = 1'b1;
               if (inst_ok && (!data_en || (streak_q == LIMIT))) begin
                  sel_d    = SEL_I;
                  wr_d     = 1'b0;
                  be_d     = 4'hF;
                  addr_d   = inst_addr;
                  wdata_d  = '0;
                  streak_d = '0;
               end else begin
                  sel_d   = SEL_D;
                  wr_d    = |data_wen;
                  be_d    = (|data_wen) ? data_wen : 4'hF;
                  addr_d  = data_addr;
                  wdata_d = data_wdata;
                  if (!inst_en)
                     streak_d = '0;
                  else if (streak_q != LIMIT)
                     streak_d = 4'(streak_q + 4'd1);
               end
            end
         end
         REQ: begin
            if (cancel_hit)
               kill_d = 1'b1;
            if (bus.mem_gnt) begin
               req_d = 1'b0;
               if (wr_q) begin
                  state_d     = DONE;
                  data_done_d = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (cancel_hit)
               kill_d = 1'b1;
            if (bus.mem_rvalid) begin
               state_d = DONE;
               if (sel_q == SEL_D) begin
                  data_rdata_d = bus.mem_rdata;
                  data_done_d  = 1'b1;
               end else if (!(kill_q || cancel_hit)) begin
                  inst_rdata_d = bus.mem_rdata;
                  inst_done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            kill_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_req   = req_q;
   assign bus.mem_wr    = wr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign inst_rdata    = inst_rdata_q;
   assign inst_done     = inst_done_q;
   assign data_rdata    = data_rdata_q;
   assign data_done     = data_done_q;
   assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: the bench plays both the CPU ports and the memory slave,
// stepping cycle by cycle and comparing outputs against hand-derived values.
module tb_cpu_mem_bridge;

   logic        clk;
   logic        reset;
   logic        inst_en;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_done;
   logic        data_en;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_done;
   logic        cancel;
   logic        bus_err;

   int unsigned n_cmp;
   int unsigned n_bad;

   cpu_mem_bridge_if bus ();

   cpu_mem_bridge #(.STARVE_LIMIT(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .inst_en    (inst_en),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .inst_done  (inst_done),
      .data_en    (data_en),
      .data_wen   (data_wen),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_done  (data_done),
      .cancel     (cancel),
      .bus        (bus.master),
      .bus_err    (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_cmp          = 0;
      n_bad          = 0;
      reset          = 1'b1;
      inst_en        = 1'b0;
      inst_addr      = '0;
      data_en        = 1'b0;
      data_wen       = '0;
      data_addr      = '0;
      data_wdata     = '0;
      cancel         = 1'b0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      check("rst_req",   bus.mem_req, 0);
      check("rst_wr",    bus.mem_wr, 0);
      check("rst_be",    bus.mem_be, 0);
      check("rst_addr",  bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_irdata", inst_rdata, 0);
      check("rst_drdata", data_rdata, 0);
      check("rst_dones", {inst_done, data_done}, 0);
      check("rst_err",   bus_err, 0);
      check("rst_streak", dut.streak_q, 0);

      // Single read, zero wait
      inst_en   = 1'b1;
      inst_addr = 32'hBFC0_0000;
      cyc;                                  // cycle 1: REQ
      check("rd_req",  bus.mem_req, 1);
      check("rd_addr", bus.mem_addr, 32'hBFC0_0000);
      check("rd_be",   bus.mem_be, 4'hF);
      check("rd_wr",   bus.mem_wr, 0);
      bus.mem_gnt = 1'b1;
      cyc;                                  // cycle 2: RESP
      check("rd_req_drop", bus.mem_req, 0);
      check("rd_done_early", inst_done, 0);
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h3C08_0001;
      cyc;                                  // cycle 3: DONE
      check("rd_done",  inst_done, 1);
      check("rd_rdata", inst_rdata, 32'h3C08_0001);
      check("rd_ddone", data_done, 0);
      bus.mem_rvalid = 1'b0;
      inst_en        = 1'b0;
      cyc;
      check("rd_done_pulse", inst_done, 0);
      check("rd_rdata_hold", inst_rdata, 32'h3C08_0001);

      // Write with two grant wait states
      data_en    = 1'b1;
      data_wen   = 4'b0011;
      data_addr  = 32'h0000_1000;
      data_wdata = 32'hAABB_CCDD;
      cyc;
      check("wr_req1",  bus.mem_req, 1);
      check("wr_wr",    bus.mem_wr, 1);
      check("wr_be",    bus.mem_be, 4'b0011);
      check("wr_addr",  bus.mem_addr, 32'h0000_1000);
      check("wr_wdata", bus.mem_wdata, 32'hAABB_CCDD);
      cyc;
      check("wr_req2",  bus.mem_req, 1);
      check("wr_addr2", bus.mem_addr, 32'h0000_1000);
      cyc;
      check("wr_req3",   bus.mem_req, 1);
      check("wr_wdata3", bus.mem_wdata, 32'hAABB_CCDD);
      check("wr_be3",    bus.mem_be, 4'b0011);
      check("wr_nodone", data_done, 0);
      bus.mem_gnt = 1'b1;
      cyc;
      check("wr_done",    data_done, 1);
      check("wr_reqdrop", bus.mem_req, 0);
      bus.mem_gnt = 1'b0;
      data_en     = 1'b0;
      cyc;
      check("wr_done_pulse", data_done, 0);

      // Simultaneous requests: data first, then instruction
      inst_en   = 1'b1;
      inst_addr = 32'h0000_0100;
      data_en   = 1'b1;
      data_wen  = 4'b0000;
      data_addr = 32'h0000_2000;
      cyc;
      check("sim_first_addr", bus.mem_addr, 32'h0000_2000);
      check("sim_rd_be",      bus.mem_be, 4'hF);
      check("sim_streak1",    dut.streak_q, 1);
      bus.mem_gnt = 1'b1;
      cyc;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1111_2222;
      cyc;
      check("sim_ddone",  data_done, 1);
      check("sim_drdata", data_rdata, 32'h1111_2222);
      check("sim_idone",  inst_done, 0);
      bus.mem_rvalid = 1'b0;
      data_en        = 1'b0;
      cyc;                                  // IDLE
      cyc;                                  // REQ for fetch
      check("sim_second_addr", bus.mem_addr, 32'h0000_0100);
      check("sim_streak0",     dut.streak_q, 0);
      bus.mem_gnt = 1'b1;
      cyc;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h3333_4444;
      cyc;
      check("sim_idone2",  inst_done, 1);
      check("sim_irdata2", inst_rdata, 32'h3333_4444);
      bus.mem_rvalid = 1'b0;
      inst_en        = 1'b0;
      cyc;

      // Starvation with STARVE_LIMIT = 2: grant order D, D, I, D
      inst_en    = 1'b1;
      inst_addr  = 32'h0000_0400;
      data_en    = 1'b1;
      data_wen   = 4'hF;
      data_addr  = 32'h0000_3000;
      data_wdata = 32'h0102_0304;
      cyc;
      check("stv_g1", bus.mem_addr, 32'h0000_3000);
      bus.mem_gnt = 1'b1;
      cyc;
      bus.mem_gnt = 1'b0;
      cyc;                                  // IDLE
      cyc;
      check("stv_g2",      bus.mem_addr, 32'h0000_3000);
      check("stv_streak2", dut.streak_q, 2);
      bus.mem_gnt = 1'b1;
      cyc;
      bus.mem_gnt = 1'b0;
      cyc;                                  // IDLE
      cyc;
      check("stv_g3",      bus.mem_addr, 32'h0000_0400);
      check("stv_g3_wr",   bus.mem_wr, 0);
      check("stv_streak0", dut.streak_q, 0);
      bus.mem_gnt = 1'b1;
      cyc;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5566_7788;
      cyc;
      check("stv_idone",  inst_done, 1);
      check("stv_irdata", inst_rdata, 32'h5566_7788);
      bus.mem_rvalid = 1'b0;
      inst_en        = 1'b0;
      cyc;                                  // IDLE
      cyc;
      check("stv_g4",    bus.mem_addr, 32'h0000_3000);
      check("stv_g4_wr", bus.mem_wr, 1);
      bus.mem_gnt = 1'b1;
      cyc;
      check("stv_ddone", data_done, 1);
      bus.mem_gnt = 1'b0;
      data_en     = 1'b0;
      cyc;

      // Cancel during RESP of a fetch
      inst_en   = 1'b1;
      inst_addr = 32'h0000_0500;
      cyc;
      check("cx_addr", bus.mem_addr, 32'h0000_0500);
      bus.mem_gnt = 1'b1;
      cyc;                                  // RESP
      bus.mem_gnt = 1'b0;
      cancel      = 1'b1;
      inst_en     = 1'b0;
      cyc;
      cancel         = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      cyc;                                  // DONE
      check("cx_nodone", inst_done, 0);
      check("cx_rdata",  inst_rdata, 32'h5566_7788);
      bus.mem_rvalid = 1'b0;
      cyc;                                  // IDLE
      check("cx_nodone2", inst_done, 0);
      check("cx_noerr",   bus_err, 0);
      check("cx_state",   dut.state_q, 0);
      check("cx_idle_req", bus.mem_req, 0);

      // Stray response in IDLE, then a normal read
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      cyc;
      bus.mem_rvalid = 1'b0;
      check("stray_err", bus_err, 1);
      check("stray_req", bus.mem_req, 0);
      data_en   = 1'b1;
      data_wen  = 4'b0000;
      data_addr = 32'h0000_0600;
      cyc;
      check("stray_rd_addr", bus.mem_addr, 32'h0000_0600);
      bus.mem_gnt = 1'b1;
      cyc;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0BAD_F00D;
      cyc;
      check("stray_ddone",  data_done, 1);
      check("stray_drdata", data_rdata, 32'h0BAD_F00D);
      check("stray_sticky", bus_err, 1);
      bus.mem_rvalid = 1'b0;
      cyc;                                  // IDLE, data_en still high
      cyc;                                  // REQ again
      check("mid_req", bus.mem_req, 1);

      // Asynchronous reset mid-transaction
      reset = 1'b1;
      #1;
      check("mid_rst_req", bus.mem_req, 0);
      check("mid_rst_err", bus_err, 0);
      data_en = 1'b0;
      cyc;
      reset = 1'b0;
      bus.mem_rvalid = 1'b1;
      cyc;
      bus.mem_rvalid = 1'b0;
      check("late_rsp_err", bus_err, 1);
      check("late_rsp_drdata", data_rdata, 0);
      cyc;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
